// File: rtl/uart_rx_word.sv
// 8N1 UART receiver that packs four little-endian bytes into a 32-bit word
// and presents it with a one-cycle strobe and an auto-incrementing address.
module uart_rx_word #(
  parameter int DIVISOR       = 78,
  parameter int DVSR_BIT      = 7,
  parameter int ADDR          = 9,
  parameter int TIMEOUT_TICKS = 320
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  output logic [31:0]     o_data,
  output logic [ADDR-1:0] o_address,
  output logic            o_valid,
  output logic            o_frame_err,
  output logic            o_timeout,
  output logic            o_busy
);
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic                r_rx_meta;
  logic                r_rx_s;
  logic [DVSR_BIT-1:0] r_div;
  logic                w_tick;
  state_t              r_state;
  logic [3:0]          r_tick_cnt;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic [23:0]         r_word;
  logic [1:0]          r_byte_cnt;
  logic [ADDR-1:0]     r_ptr;
  logic [TO_W-1:0]     r_to_cnt;
  logic                r_wait_high;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_tick = (r_div == DVSR_BIT'(DIVISOR - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_word      <= '0;
      r_byte_cnt  <= '0;
      r_ptr       <= '0;
      r_to_cnt    <= '0;
      r_wait_high <= 1'b0;
      o_data      <= '0;
      o_address   <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_timeout   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_timeout   <= 1'b0;
      case (r_state)
        IDLE: begin
          // After a frame error the line must go high before a new start counts.
          if (r_wait_high) begin
            if (r_rx_s) r_wait_high <= 1'b0;
          end else if (!r_rx_s) begin
            r_tick_cnt <= '0;
            r_to_cnt   <= '0;
            r_state    <= START;
            o_busy     <= 1'b1;
          end else if (r_byte_cnt != 2'd0 && w_tick) begin
            if (r_to_cnt == TO_W'(TIMEOUT_TICKS - 1)) begin
              r_byte_cnt <= '0;
              r_to_cnt   <= '0;
              o_timeout  <= 1'b1;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
        end
        START: begin
          if (w_tick) begin
            if (r_tick_cnt == 4'd7) begin
              if (r_rx_s) begin
                r_state <= IDLE;
                o_busy  <= 1'b0;
              end else begin
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
                r_state    <= DATA;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_tick_cnt == 4'd15) begin
              r_shift    <= {r_rx_s, r_shift[7:1]};
              r_tick_cnt <= '0;
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) r_state <= STOP;
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_tick_cnt == 4'd15) begin
              r_tick_cnt <= '0;
              r_state    <= IDLE;
              o_busy     <= 1'b0;
              if (!r_rx_s) begin
                o_frame_err <= 1'b1;
                r_byte_cnt  <= '0;
                r_wait_high <= 1'b1;
              end else if (r_byte_cnt == 2'd3) begin
                o_data     <= {r_shift, r_word};
                o_address  <= r_ptr;
                o_valid    <= 1'b1;
                r_ptr      <= r_ptr + 1'b1;
                r_byte_cnt <= '0;
              end else begin
                case (r_byte_cnt)
                  2'd0:    r_word[7:0]   <= r_shift;
                  2'd1:    r_word[15:8]  <= r_shift;
                  default: r_word[23:16] <= r_shift;
                endcase
                r_byte_cnt <= r_byte_cnt + 2'd1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_word.sv
// Randomised bench for uart_rx_word: a byte-list model predicts words, frame
// errors and timeouts from the frames and gaps the bench itself sends.
module tb_uart_rx_word;
  localparam int DIV     = 2;
  localparam int DVSR    = 1;
  localparam int AW      = 4;
  localparam int TO      = 320;
  localparam int BIT_CLK = 16 * DIV;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx = 1'b1;
  logic [31:0]   o_data;
  logic [AW-1:0] o_address;
  logic          o_valid;
  logic          o_frame_err;
  logic          o_timeout;
  logic          o_busy;

  always #5 clk = ~clk;

  uart_rx_word #(
    .DIVISOR(DIV), .DVSR_BIT(DVSR), .ADDR(AW), .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .o_data(o_data), .o_address(o_address), .o_valid(o_valid),
    .o_frame_err(o_frame_err), .o_timeout(o_timeout), .o_busy(o_busy)
  );

  typedef struct {
    logic [31:0]   data;
    logic [AW-1:0] addr;
  } word_t;

  int        n_checks = 0;
  int        n_fail = 0;
  logic [7:0] m_bytes[$];
  word_t     exp_q[$];
  word_t     mon_w;
  int        m_ptr = 0;
  int        exp_words = 0, exp_ferr = 0, exp_to = 0;
  int        act_words = 0, act_ferr = 0, act_to = 0;
  bit        saw_wrap = 1'b0;
  logic [AW-1:0] last_addr = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: good bytes accumulate; four make a word; a bad stop drops them.
  task automatic model_byte(input logic [7:0] b, input bit good);
    word_t w;
    if (!good) begin
      exp_ferr++;
      m_bytes.delete();
    end else begin
      m_bytes.push_back(b);
      if (m_bytes.size() == 4) begin
        w.data = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
        w.addr = AW'(m_ptr);
        m_ptr  = (m_ptr + 1) % (1 << AW);
        exp_q.push_back(w);
        exp_words++;
        m_bytes.delete();
      end
    end
  endtask

  // The receiver is idle from mid stop bit, so the idle span is gap + 8 ticks.
  task automatic idle_ticks(input int t);
    rx = 1'b1;
    if (m_bytes.size() != 0 && t + 8 >= TO) begin
      exp_to++;
      m_bytes.delete();
    end
    repeat (t * DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good);
    model_byte(b, good);
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx = good;
    repeat (BIT_CLK) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      idle_ticks(4);
      send_frame(w[8*i +: 8], 1'b1);
    end
  endtask

  task automatic checkpoint(input string tag);
    idle_ticks(20);
    check_eq({tag, "_words"}, act_words, exp_words);
    check_eq({tag, "_ferr"}, act_ferr, exp_ferr);
    check_eq({tag, "_timeout"}, act_to, exp_to);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (o_valid) begin
        act_words++;
        $display("word %0d: addr=%0d data=0x%08h", act_words, o_address, o_data);
        if (exp_q.size() != 0) begin
          mon_w = exp_q.pop_front();
          check_eq("word_data", o_data, mon_w.data);
          check_eq("word_addr", 32'(o_address), 32'(mon_w.addr));
        end
        if (act_words > 1 && o_address == '0 && last_addr == '1) saw_wrap = 1'b1;
        last_addr = o_address;
      end
      if (o_frame_err) act_ferr++;
      if (o_timeout) act_to++;
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    reset = 1'b0;
    rx    = 1'b1;
    repeat (200) @(negedge clk);
    check_eq("rst_data", o_data, 32'd0);
    check_eq("rst_addr", 32'(o_address), 32'd0);
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_ferr", 32'(o_frame_err), 32'd0);
    check_eq("rst_timeout", 32'(o_timeout), 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    reset = 1'b1;
    idle_ticks(20);

    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    checkpoint("basic");

    idle_ticks(4); send_frame(8'h11, 1'b1);
    idle_ticks(4); send_frame(8'h22, 1'b1);
    idle_ticks(4); send_frame(8'h55, 1'b0);
    send_word(32'hDDCCBBAA);
    checkpoint("frame_err");

    idle_ticks(4); send_frame(8'h01, 1'b1);
    idle_ticks(330);
    send_word(32'h01020304);
    checkpoint("timeout");

    rx = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    check_eq("glitch_busy_hi", 32'(o_busy), 32'd1);
    repeat (2 * DIV) @(negedge clk);
    rx = 1'b1;
    repeat (8 * DIV) @(negedge clk);
    check_eq("glitch_busy_lo", 32'(o_busy), 32'd0);
    checkpoint("glitch");

    while (exp_words < 22) begin
      gap = ($urandom_range(0, 15) == 0) ? int'($urandom_range(340, 400))
                                         : int'($urandom_range(2, 40));
      idle_ticks(gap);
      send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 11) != 0);
    end
    checkpoint("random");
    check_eq("addr_wrap", 32'(saw_wrap), 32'd1);

    idle_ticks(10);
    idle_ticks(4); send_frame(8'hA1, 1'b1);
    idle_ticks(4); send_frame(8'hB2, 1'b1);
    idle_ticks(4);
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = i[0] ? 1'b0 : 1'b1;
      repeat (BIT_CLK) @(negedge clk);
    end
    reset = 1'b0;
    rx    = 1'b1;
    m_bytes.delete();
    m_ptr = 0;
    repeat (20) @(negedge clk);
    check_eq("midrst_data", o_data, 32'd0);
    check_eq("midrst_addr", 32'(o_address), 32'd0);
    check_eq("midrst_busy", 32'(o_busy), 32'd0);
    reset = 1'b1;
    idle_ticks(10);
    send_word(32'hCAFEF00D);
    checkpoint("reset_mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
